afifo_wr_ctrl: RTL and testbench
================================

Name: afifo_wr_ctrl

Overview:
Write-domain half of the dual-clock 4-bit FIFO. It accepts write requests on wclk and drives the shared memory write port. It exports a Gray-coded write pointer to the read domain and resynchronises the read domain's Gray pointer to compute full, almost-full and occupancy. The block replaces the shared cross-domain count with a CDC-safe pointer exchange; the read-domain controller is the mirror block.

Parameters:
DW, 4, data width in bits
DEPTH, 8, FIFO depth; power of two, >= 4
AW, $clog2(DEPTH), memory address width (derived; not overridden)
AF_MARGIN, 2, almost_full asserts when free slots <= AF_MARGIN; 1 <= AF_MARGIN < DEPTH

Ports:
wclk  in  1  write clock
rst  in  1  reset, asynchronous, active-high; clears all state
wr_req  in  1  write request, sampled on wclk rising edge
wr_data  in  DW  data to write
rq_gray_async  in  AW+1  read pointer, Gray-coded, from rclk domain (asynchronous)
overflow_clr  in  1  clears sticky overflow
mem_we  out  1  memory write strobe
mem_waddr  out  AW  memory write address
mem_wdata  out  DW  memory write data
wptr_gray  out  AW+1  registered Gray write pointer, to read domain
full  out  1  FIFO full (write side view)
almost_full  out  1  free slots <= AF_MARGIN
level  out  AW+1  write-side occupancy, 0..DEPTH
wr_ack  out  1  write accepted this cycle
overflow  out  1  sticky: write attempted while full

Behaviour:
- State: wbin (AW+1 bit binary write pointer), wgray (registered), rq_s1/rq_s2 (2-flop synchroniser), overflow.
- Reset (async assert, values held while rst=1): wbin=0, wgray=0, rq_s1=rq_s2=0, overflow=0. Outputs in reset: full=0, almost_full=0, level=0, wr_ack=0, mem_we=0, wptr_gray=0.
- rq_gray_async passes through rq_s1 -> rq_s2 every wclk; only rq_s2 is used. Read progress is visible 2 wclk later, so full/level are pessimistic, never optimistic.
- rbin_s = gray2bin(rq_s2); level = (wbin - rbin_s) mod 2^(AW+1), combinational from registers.
- full = (wgray == {~rq_s2[AW:AW-1], rq_s2[AW-2:0]}), equivalent to level == DEPTH.
- almost_full = (level >= DEPTH - AF_MARGIN).
- Accept = wr_req & ~full, combinational. In the same cycle: mem_we=1, wr_ack=1, mem_waddr=wbin[AW-1:0], mem_wdata=wr_data.
- On the edge after accept: wbin <= wbin+1 (wraps mod 2^(AW+1)), wgray <= bin2gray(wbin+1). wptr_gray = wgray, so it is glitch-free, registered and changes exactly one bit per increment.
- When not accepting: mem_we=0, wr_ack=0, pointers hold. mem_waddr/mem_wdata still follow wbin/wr_data (don't-care to memory).
- Write while full (wr_req & full): dropped; no pointer change; overflow <= 1.
- overflow: set has priority over overflow_clr in the same cycle; otherwise overflow_clr=1 clears it.
- Wrap-around: after 2^(AW+1) writes wbin returns to 0. MSB difference versus the read pointer distinguishes full from empty.
- Full to not-full: full deasserts 2 wclk after the read-side Gray pointer changes. A write in that first non-full cycle is accepted.
- Reset mid-operation: immediate clear regardless of wclk. No memory clear is needed; the read side is reset by the same rst.
- rq_gray_async must be a registered Gray pointer from rclk. A non-Gray input is outside the spec.

Decomposition:
- Package afifo_pkg: bin2gray/gray2bin functions (parameterised width); default DW/DEPTH localparams. Shared with the read controller.
- Sub-module sync_2ff (width param, rst async clear). It is reused by the read controller for wptr_gray.

Test Plan:
- Reset: rst=1 for 3 cycles with wr_req=1 -> mem_we=0, wptr_gray=0, level=0, full=0, overflow=0 throughout.
- Fill: rq_gray_async=0, 8 consecutive writes of 0x1..0x8 -> mem_waddr 0..7 with matching data. almost_full rises when level=6. full=1 after the 8th write; wptr_gray=4'b1100 (gray(8)).
- Overflow: full state, wr_req=1 for 1 cycle with data 0xF -> mem_we=0, wbin unchanged, overflow=1. overflow_clr and wr_req together while full -> overflow stays 1. overflow_clr alone -> 0.
- Drain lag: from full, set rq_gray_async=gray(3)=4'b0010 -> full stays 1 for 1 cycle, deasserts on the 2nd edge, level=5.
- Wrap: stream 20 writes with rq_gray_async tracking gray(wbin-2) -> wptr_gray changes exactly one bit per accept, wbin wraps 15->0, mem_waddr wraps 7->0, full never set.
- Reset mid-stream: assert rst asynchronously between edges at level=5 -> level, wptr_gray and full go to 0 immediately; the first write after release goes to mem_waddr=0.

Source files
------------

// File: rtl/afifo_pkg.sv
// Shared definitions for the dual-clock FIFO controllers: default sizes and
// Gray/binary pointer conversion used by both the write and read halves.
package afifo_pkg;

    localparam int DEF_DW    = 4;
    localparam int DEF_DEPTH = 8;

    // Functions work on 32-bit values; callers zero-extend and truncate to
    // their own pointer width, which leaves the result unchanged.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the clk domain.
// Asynchronously cleared so both FIFO halves agree immediately after reset.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-domain controller of the dual-clock FIFO: drives the memory write
// port, exports a registered Gray write pointer and derives full/level.
module afifo_wr_ctrl
    import afifo_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_MARGIN = 2,
    localparam int AW       = $clog2(DEPTH),
    localparam int PW       = AW + 1
) (
    input  logic          wclk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [DW-1:0] wr_data,
    input  logic [PW-1:0] rq_gray_async,
    input  logic          overflow_clr,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [PW-1:0] wptr_gray,
    output logic          full,
    output logic          almost_full,
    output logic [PW-1:0] level,
    output logic          wr_ack,
    output logic          overflow
);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wgray;
    logic [PW-1:0] wbin_inc;
    logic [PW-1:0] rq_s2;
    logic [PW-1:0] rbin_s;
    logic          accept;

    sync_2ff #(.W(PW)) u_rq_sync (
        .clk (wclk),
        .rst (rst),
        .d   (rq_gray_async),
        .q   (rq_s2)
    );

    // The read pointer seen here lags by two wclk, so level/full can only
    // over-estimate occupancy; a write is never accepted into a used slot.
    assign rbin_s      = PW'(gray2bin(32'(rq_s2)));
    assign level       = wbin - rbin_s;
    assign full        = (wgray == {~rq_s2[AW:AW-1], rq_s2[AW-2:0]});
    assign almost_full = (level >= PW'(DEPTH - AF_MARGIN));

    // Handshake: a write is taken in any cycle where wr_req is high and the
    // FIFO is not full; wr_ack/mem_we mark exactly that cycle. wr_req need
    // not be held, and a request made while full is dropped, not stalled.
    assign accept    = wr_req & ~full & ~rst;
    assign mem_we    = accept;
    assign wr_ack    = accept;
    assign mem_waddr = wbin[AW-1:0];
    assign mem_wdata = wr_data;
    assign wptr_gray = wgray;
    assign wbin_inc  = wbin + 1'b1;

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            wbin  <= '0;
            wgray <= '0;
        end else if (accept) begin
            wbin  <= wbin_inc;
            wgray <= PW'(bin2gray(32'(wbin_inc)));
        end
    end

    // A fresh overflow wins over a clear arriving in the same cycle.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_req && full) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Self-checking bench for afifo_wr_ctrl (DW=4, DEPTH=8, AF_MARGIN=2).
// Accepted writes are predicted into a queue and matched on mem_we.
module tb_afifo_wr_ctrl;

    localparam int DW = 4;
    localparam int AW = 3;
    localparam int PW = 4;

    logic          wclk;
    logic          rst;
    logic          wr_req;
    logic [DW-1:0] wr_data;
    logic [PW-1:0] rq_gray_async;
    logic          overflow_clr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [PW-1:0] wptr_gray;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] level;
    logic          wr_ack;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [PW-1:0]    m_wptr;

    afifo_wr_ctrl dut (
        .wclk          (wclk),
        .rst           (rst),
        .wr_req        (wr_req),
        .wr_data       (wr_data),
        .rq_gray_async (rq_gray_async),
        .overflow_clr  (overflow_clr),
        .mem_we        (mem_we),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .wptr_gray     (wptr_gray),
        .full          (full),
        .almost_full   (almost_full),
        .level         (level),
        .wr_ack        (wr_ack),
        .overflow      (overflow)
    );

    // clock / reset
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // scoreboard: every memory write strobe must match the oldest prediction
    always @(negedge wclk) begin
        if (mem_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got addr=%0d data=%h, expected no write", mem_waddr, mem_wdata);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                if ({mem_waddr, mem_wdata} !== e) begin
                    bad++;
                    $display("FAIL sb_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             mem_waddr, mem_wdata, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
            total++;
            if (wr_ack !== 1'b1) begin
                bad++;
                $display("FAIL sb_ack: got wr_ack=%b, expected 1 with mem_we", wr_ack);
            end
        end
    end

    // driver: one write request in the cycle following the next rising edge
    task automatic drive(input logic req, input logic [DW-1:0] d);
        @(posedge wclk);
        #1;
        wr_req  = req;
        wr_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_req = 1'b1; wr_data = 4'h9; rq_gray_async = '0; overflow_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge wclk);
            total++;
            if ({mem_we, wptr_gray, level, full, overflow} !== 11'b0) begin
                bad++;
                $display("FAIL reset_state: got we=%b gray=%b level=%0d full=%b ovf=%b, expected all 0",
                         mem_we, wptr_gray, level, full, overflow);
            end
        end
        @(posedge wclk);
        #1;
        rst = 1'b0; wr_req = 1'b0;
        m_wptr = '0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] d;
            d = DW'(i + 1);
            drive(1'b1, d);
            exp_q.push_back({AW'(i), d});
            @(negedge wclk);
            total++;
            if (level !== PW'(i) || almost_full !== (i >= 6) || full !== 1'b0) begin
                bad++;
                $display("FAIL fill_step%0d: got level=%0d af=%b full=%b, expected level=%0d af=%b full=0",
                         i, level, almost_full, full, i, (i >= 6));
            end
            m_wptr = m_wptr + 1'b1;
        end
        drive(1'b0, '0);
        @(negedge wclk);
        total++;
        if (full !== 1'b1 || level !== 4'd8 || wptr_gray !== 4'b1100 || almost_full !== 1'b1) begin
            bad++;
            $display("FAIL fill_full: got full=%b level=%0d gray=%b af=%b, expected 1 8 1100 1",
                     full, level, wptr_gray, almost_full);
        end
    endtask

    task automatic test_overflow();
        drive(1'b1, 4'hF);
        @(negedge wclk);
        total++;
        if (mem_we !== 1'b0 || wr_ack !== 1'b0) begin
            bad++;
            $display("FAIL ovf_drop: got we=%b ack=%b, expected 0 0", mem_we, wr_ack);
        end
        drive(1'b0, '0);
        @(negedge wclk);
        total++;
        if (overflow !== 1'b1 || level !== 4'd8 || wptr_gray !== gray(m_wptr)) begin
            bad++;
            $display("FAIL ovf_set: got ovf=%b level=%0d gray=%b, expected 1 8 %b",
                     overflow, level, wptr_gray, gray(m_wptr));
        end
        overflow_clr = 1'b1;
        drive(1'b1, 4'hE);
        drive(1'b0, '0);
        overflow_clr = 1'b0;
        @(negedge wclk);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_priority: got ovf=%b, expected 1", overflow);
        end
        overflow_clr = 1'b1;
        drive(1'b0, '0);
        overflow_clr = 1'b0;
        @(negedge wclk);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: got ovf=%b, expected 0", overflow);
        end
    endtask

    task automatic test_drain_lag();
        @(posedge wclk);
        #1;
        rq_gray_async = 4'b0010;
        @(negedge wclk);
        total++;
        if (full !== 1'b1) begin
            bad++;
            $display("FAIL drain_edge0: got full=%b, expected 1", full);
        end
        @(negedge wclk);
        total++;
        if (full !== 1'b1) begin
            bad++;
            $display("FAIL drain_edge1: got full=%b, expected 1", full);
        end
        @(negedge wclk);
        total++;
        if (full !== 1'b0 || level !== 4'd5 || almost_full !== 1'b0) begin
            bad++;
            $display("FAIL drain_edge2: got full=%b level=%0d af=%b, expected 0 5 0", full, level, almost_full);
        end
    endtask

    task automatic test_wrap();
        logic [PW-1:0] prev_g;
        prev_g = wptr_gray;
        for (int k = 0; k < 20; k++) begin
            logic [DW-1:0] d;
            d = DW'($urandom_range(0, 15));
            drive(1'b1, d);
            rq_gray_async = gray(m_wptr - 4'd2);
            exp_q.push_back({m_wptr[AW-1:0], d});
            @(negedge wclk);
            total++;
            if (full !== 1'b0 || wr_ack !== 1'b1 || wptr_gray !== gray(m_wptr)) begin
                bad++;
                $display("FAIL wrap_step%0d: got full=%b ack=%b gray=%b, expected 0 1 %b",
                         k, full, wr_ack, wptr_gray, gray(m_wptr));
            end
            if (k > 0) begin
                total++;
                if ($countones(prev_g ^ wptr_gray) != 1) begin
                    bad++;
                    $display("FAIL wrap_onebit%0d: got %b -> %b, expected one bit change", k, prev_g, wptr_gray);
                end
            end
            prev_g = wptr_gray;
            m_wptr = m_wptr + 1'b1;
        end
        drive(1'b0, '0);
        @(negedge wclk);
        total++;
        if (wptr_gray !== gray(m_wptr) || full !== 1'b0) begin
            bad++;
            $display("FAIL wrap_end: got gray=%b full=%b, expected %b 0", wptr_gray, full, gray(m_wptr));
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            logic [DW-1:0] d;
            d = DW'($urandom_range(0, 15));
            drive(1'b1, d);
            exp_q.push_back({m_wptr[AW-1:0], d});
            m_wptr = m_wptr + 1'b1;
        end
        drive(1'b0, '0);
        @(negedge wclk);
        total++;
        if (level !== 4'd5) begin
            bad++;
            $display("FAIL rstmid_pre: got level=%0d, expected 5", level);
        end
        #2;
        rst = 1'b1;
        rq_gray_async = '0;
        #1;
        total++;
        if (level !== 4'd0 || wptr_gray !== 4'd0 || full !== 1'b0 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async: got level=%0d gray=%b full=%b we=%b, expected 0 0000 0 0",
                     level, wptr_gray, full, mem_we);
        end
        m_wptr = '0;
        @(posedge wclk);
        #1;
        rst = 1'b0;
        drive(1'b1, 4'hA);
        exp_q.push_back({3'd0, 4'hA});
        @(negedge wclk);
        total++;
        if (mem_we !== 1'b1 || mem_waddr !== 3'd0) begin
            bad++;
            $display("FAIL rstmid_first: got we=%b addr=%0d, expected 1 0", mem_we, mem_waddr);
        end
        drive(1'b0, '0);
        @(negedge wclk);
        total++;
        if (level !== 4'd1 || wptr_gray !== 4'b0001) begin
            bad++;
            $display("FAIL rstmid_after: got level=%0d gray=%b, expected 1 0001", level, wptr_gray);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain_lag();
        test_wrap();
        test_reset_mid();
        repeat (2) @(posedge wclk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d writes missing, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
